seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 4..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have port A_bus  input  WIDTH  operand A.
REQ-007 SHALL have port B_bus  input  WIDTH  operand B.
REQ-008 SHALL have port F  input  4  operation select, alu_op_e encoding.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port C  output  WIDTH  registered result.
REQ-012 SHALL have ports CF, ZF, NF, OF  output  1 each  carry, zero, negative and signed-overflow flags, registered with C.

Function
REQ-013 SHALL accept a request on a rising edge where in_valid && in_ready, capturing A_bus, B_bus and F.
REQ-014 SHALL implement the F encoding: 0 PASS_A, 1 PASS_B, 2 ADD, 3 SUB, 4 INC(A), 5 DEC(A), 6 AND, 7 OR, 8 XOR, 9 NOT(A), A SHL(A,1), B SHR(A,1), C ROL(A,1), D ROR(A,1), E MUL, F CMP.
REQ-015 SHALL set CF to: carry-out for ADD/INC; borrow (A<B unsigned) for SUB/CMP; borrow for DEC (A==0); the bit shifted or rotated out for SHL/SHR/ROL/ROR; 1 if the upper WIDTH product bits are nonzero for MUL; 0 otherwise.
REQ-016 SHALL set ZF = (C==0), NF = C[WIDTH-1], and OF = signed overflow for ADD/SUB/INC/DEC/CMP, OF=0 for all other ops.
REQ-017 CMP SHALL output C = A_bus unchanged, with CF/OF from A-B and ZF/NF computed from A-B.
REQ-018 MUL SHALL output C = low WIDTH bits of the unsigned product.
REQ-019 SHALL use the FSM IDLE, BUSY, DONE: IDLE->DONE on accepted non-MUL; IDLE->BUSY on accepted MUL; BUSY->DONE after WIDTH cycles; DONE->IDLE on out_ready with no new accept; DONE->DONE or DONE->BUSY on out_ready with a simultaneous accept.
REQ-020 SHALL hold out_valid=1 only in DONE; C and flags SHALL remain stable while out_valid && !out_ready.
REQ-021 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready), which gives one non-MUL op per cycle when back-to-back.
REQ-022 Latency: a non-MUL result SHALL be valid on the edge after acceptance; a MUL result SHALL be valid WIDTH+1 edges after acceptance.
REQ-023 SHALL ignore in_valid while in BUSY, with in_ready=0 in that state.
REQ-024 All arithmetic SHALL be unsigned modulo 2^WIDTH; no X may propagate to outputs for any F value.

Reset
REQ-025 On rst_n low, SHALL immediately enter IDLE and force out_valid=0, C=0, CF=ZF=NF=OF=0, and the MUL counter and partial product to 0.
REQ-026 Reset asserted mid-MUL SHALL abort the operation with no result emitted; after release, in_ready=1 on the first cycle.

Structure
REQ-027 SHALL take alu_op_e (4-bit op enum) and alu_state_e (IDLE/BUSY/DONE) from shared package alu_pkg.
REQ-028 SHALL place the serial shift-add multiplier in sub-module alu_mul_serial (start, done, WIDTH-cycle iteration, 2*WIDTH product).

Verification (WIDTH=8)
REQ-029 SHALL cover: ADD A=0xFF B=0x01 -> C=0x00, CF=1, ZF=1, OF=0, out_valid one edge after accept.
REQ-030 SHALL cover: SUB A=0x00 B=0x01 -> C=0xFF, CF=1, NF=1; ADD 0x7F+0x01 -> C=0x80, OF=1, NF=1.
REQ-031 SHALL cover: MUL A=0x10 B=0x10 -> C=0x00, CF=1, ZF=1, valid 9 edges after accept, in_ready=0 throughout BUSY; MUL 0x0F*0x11 -> C=0xFF, CF=0.
REQ-032 SHALL cover: out_ready held low 3 cycles in DONE -> C/flags/out_valid stable and in_ready=0; then 8 back-to-back XOR ops with out_ready=1 -> one result per cycle.
REQ-033 SHALL cover: rst_n pulsed low 4 cycles into a MUL -> outputs 0 immediately, no stale result after release, next ADD 0x02+0x03 -> C=0x05.
REQ-034 SHALL cover: CMP A=0x05 B=0x05 -> C=0x05, ZF=1, CF=0; ROR A=0x01 -> C=0x80, CF=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: operation and FSM state encodings shared by seq_alu and its multiplier
package alu_pkg;
    typedef enum logic [3:0] {
        OP_PASS_A = 4'h0, OP_PASS_B = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
        OP_INC    = 4'h4, OP_DEC    = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
        OP_XOR    = 4'h8, OP_NOT    = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB,
        OP_ROL    = 4'hC, OP_ROR    = 4'hD, OP_MUL = 4'hE, OP_CMP = 4'hF
    } alu_op_e;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;
endpackage

// File: rtl/alu_mul_serial.sv
// alu_mul_serial: shift-add multiplier, one multiplier bit per cycle, WIDTH cycles per product
module alu_mul_serial #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);
    localparam int CW = $clog2(WIDTH);
    logic               busy_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] mcand_q, acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q;
    // partial product after folding in the current multiplier bit
    always_comb acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    // done flags the final iteration, so product_o is already complete at that edge
    assign done_o    = busy_q && cnt_q == CW'(WIDTH - 1);
    assign product_o = acc_d;
    // load operands on start, then shift and accumulate until the last bit is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
        end else if (busy_q) begin
            busy_q   <= !done_o;
            cnt_q    <= cnt_q + 1'b1;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_d;
        end
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU, single-cycle ops plus a multi-cycle serial multiply
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A_bus,
    input  logic [WIDTH-1:0] B_bus,
    input  logic [3:0]       F,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             CF,
    output logic             ZF,
    output logic             NF,
    output logic             OF
);
    localparam int M = WIDTH - 1;
    alu_state_e           state_q, state_d;
    alu_op_e              op;
    logic                 accept, is_mul, mul_done, add_of, sub_of, res_cf, res_of;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH:0]       sum, diff;
    logic [WIDTH-1:0]     opb, res, flag_src;
    logic [WIDTH+3:0]     out_q, out_d;
    assign op       = alu_op_e'(F);
    assign accept   = in_valid && in_ready;
    assign is_mul   = op == OP_MUL;
    assign opb      = (op == OP_INC || op == OP_DEC) ? WIDTH'(1) : B_bus;
    assign sum      = {1'b0, A_bus} + {1'b0, opb};
    assign diff     = {1'b0, A_bus} - {1'b0, opb};
    assign add_of   = (A_bus[M] == opb[M]) && (sum[M] != A_bus[M]);
    assign sub_of   = (A_bus[M] != opb[M]) && (diff[M] != A_bus[M]);
    // CMP passes A through but reports Z/N of the difference
    assign flag_src = op == OP_CMP ? diff[M:0] : res;
    assign {C, CF, ZF, NF, OF} = out_q;
    alu_mul_serial #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (accept && is_mul),
        .a_i       (A_bus),
        .b_i       (B_bus),
        .done_o    (mul_done),
        .product_o (product)
    );
    // single-cycle result and carry/overflow for every non-MUL op
    always_comb begin
        res    = '0;
        res_cf = 1'b0;
        res_of = 1'b0;
        case (op)
            OP_PASS_A:      res = A_bus;
            OP_PASS_B:      res = B_bus;
            OP_ADD, OP_INC: begin res = sum[M:0];  res_cf = sum[WIDTH];  res_of = add_of; end
            OP_SUB, OP_DEC: begin res = diff[M:0]; res_cf = diff[WIDTH]; res_of = sub_of; end
            OP_CMP:         begin res = A_bus;     res_cf = diff[WIDTH]; res_of = sub_of; end
            OP_AND:         res = A_bus & B_bus;
            OP_OR:          res = A_bus | B_bus;
            OP_XOR:         res = A_bus ^ B_bus;
            OP_NOT:         res = ~A_bus;
            OP_SHL:         begin res = {A_bus[M-1:0], 1'b0};   res_cf = A_bus[M]; end
            OP_SHR:         begin res = {1'b0, A_bus[M:1]};     res_cf = A_bus[0]; end
            OP_ROL:         begin res = {A_bus[M-1:0], A_bus[M]}; res_cf = A_bus[M]; end
            OP_ROR:         begin res = {A_bus[0], A_bus[M:1]};   res_cf = A_bus[0]; end
            default:        res = '0;
        endcase
    end
    // result register loads on a non-MUL accept or on multiplier completion, otherwise holds
    always_comb begin
        out_d = out_q;
        if (accept && !is_mul)
            out_d = {res, res_cf, flag_src == '0, flag_src[M], res_of};
        else if (state_q == ST_BUSY && mul_done)
            out_d = {product[M:0], |product[2*WIDTH-1:WIDTH], product[M:0] == '0, product[M], 1'b0};
    end
    // result and flags storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= out_d;
    end
    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end
    // FSM next state: a DONE with out_ready can hand straight over to the next op
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = accept ? (is_mul ? ST_BUSY : ST_DONE) : ST_IDLE;
            ST_BUSY: state_d = mul_done ? ST_DONE : ST_BUSY;
            ST_DONE: state_d = accept ? (is_mul ? ST_BUSY : ST_DONE) : (out_ready ? ST_IDLE : ST_DONE);
            default: state_d = ST_IDLE;
        endcase
    end
    // FSM outputs: handshake signals
    always_comb begin
        in_ready  = state_q == ST_IDLE || (state_q == ST_DONE && out_ready);
        out_valid = state_q == ST_DONE;
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: vector table, directed handshake/reset sequences and random ops vs an arithmetic model
module tb_seq_alu;
    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, out_valid, out_ready, CF, ZF, NF, OF;
    logic [7:0] A_bus, B_bus, C;
    logic [3:0] F;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A_bus(A_bus), .B_bus(B_bus), .F(F), .out_valid(out_valid),
        .out_ready(out_ready), .C(C), .CF(CF), .ZF(ZF), .NF(NF), .OF(OF)
    );

    typedef struct {
        logic [3:0] f;
        logic [7:0] a, b, c;
        logic       cf, zf, nf, of;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // result as {C, CF, ZF, NF, OF} from plain integer arithmetic
    function automatic logic [11:0] model(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        int ia, ib, sa, sb, r, sr;
        logic cf, of;
        logic [7:0] c, z;
        ia = int'(a); ib = int'(b);
        sa = ia > 127 ? ia - 256 : ia;
        sb = ib > 127 ? ib - 256 : ib;
        r = 0; sr = 0; cf = 1'b0; of = 1'b0;
        case (f)
            4'h0: r = ia;
            4'h1: r = ib;
            4'h2: begin r = ia + ib; cf = r > 255;  sr = sa + sb; of = sr > 127 || sr < -128; end
            4'h3, 4'hF: begin r = ia - ib; cf = ia < ib; sr = sa - sb; of = sr > 127 || sr < -128; end
            4'h4: begin r = ia + 1; cf = r > 255;  sr = sa + 1; of = sr > 127; end
            4'h5: begin r = ia - 1; cf = ia == 0;  sr = sa - 1; of = sr < -128; end
            4'h6: r = int'(a & b);
            4'h7: r = int'(a | b);
            4'h8: r = int'(a ^ b);
            4'h9: r = 255 - ia;
            4'hA: begin r = ia * 2; cf = ia >= 128; end
            4'hB: begin r = ia / 2; cf = ia % 2 == 1; end
            4'hC: begin r = (ia * 2) % 256 + ia / 128; cf = ia >= 128; end
            4'hD: begin r = ia / 2 + (ia % 2) * 128; cf = ia % 2 == 1; end
            default: begin r = ia * ib; cf = r > 255; end
        endcase
        c = 8'(((r % 256) + 256) % 256);
        z = c;
        if (f == 4'hF) c = a;
        return {c, cf, z == 8'h00, z >= 8'h80, of};
    endfunction

    // issue one op from IDLE, measure edges until out_valid, optionally stall, then consume
    task automatic do_op(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                         input int stall, output logic [11:0] got, output int lat);
        in_valid = 1'b1; F = f; A_bus = a; B_bus = b;
        @(posedge clk); #1;
        if (f == 4'hE) begin
            F = 4'h1; A_bus = ~a; B_bus = ~b;
        end else in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk("busy_in_ready", in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        got = {C, CF, ZF, NF, OF};
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_hold", {C, CF, ZF, NF, OF}, got);
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input string name, input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                       input logic [11:0] exp, input int stall);
        logic [11:0] got;
        int lat;
        do_op(f, a, b, stall, got, lat);
        chk($sformatf("%s_lat", name), lat, f == 4'hE ? 9 : 1);
        chk($sformatf("%s_res", name), got, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[18];
        logic [7:0] xa, xb;
        int seen;
        tbl[0]  = '{4'h2, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0};
        tbl[1]  = '{4'h3, 8'h00, 8'h01, 8'hFF, 1, 0, 1, 0};
        tbl[2]  = '{4'h2, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1};
        tbl[3]  = '{4'hE, 8'h10, 8'h10, 8'h00, 1, 1, 0, 0};
        tbl[4]  = '{4'hE, 8'h0F, 8'h11, 8'hFF, 0, 0, 1, 0};
        tbl[5]  = '{4'hF, 8'h05, 8'h05, 8'h05, 0, 1, 0, 0};
        tbl[6]  = '{4'hD, 8'h01, 8'h00, 8'h80, 1, 0, 1, 0};
        tbl[7]  = '{4'h5, 8'h00, 8'h00, 8'hFF, 1, 0, 1, 0};
        tbl[8]  = '{4'h4, 8'h7F, 8'h00, 8'h80, 0, 0, 1, 1};
        tbl[9]  = '{4'hA, 8'h81, 8'h00, 8'h02, 1, 0, 0, 0};
        tbl[10] = '{4'hB, 8'h01, 8'h00, 8'h00, 1, 1, 0, 0};
        tbl[11] = '{4'hC, 8'h80, 8'h00, 8'h01, 1, 0, 0, 0};
        tbl[12] = '{4'h9, 8'h0F, 8'h00, 8'hF0, 0, 0, 1, 0};
        tbl[13] = '{4'hF, 8'h03, 8'h05, 8'h03, 1, 0, 1, 0};
        tbl[14] = '{4'h3, 8'h80, 8'h01, 8'h7F, 0, 0, 0, 1};
        tbl[15] = '{4'h6, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0};
        tbl[16] = '{4'h0, 8'h00, 8'hAA, 8'h00, 0, 1, 0, 0};
        tbl[17] = '{4'h1, 8'h00, 8'hAA, 8'hAA, 0, 0, 1, 0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A_bus = '0; B_bus = '0; F = '0;
        #3;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", {C, CF, ZF, NF, OF}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_in_ready", in_ready, 1);

        for (int i = 0; i < 18; i++)
            run($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].b,
                {tbl[i].c, tbl[i].cf, tbl[i].zf, tbl[i].nf, tbl[i].of}, i == 0 ? 3 : 0);

        out_ready = 1'b1; in_valid = 1'b1; F = 4'h8;
        for (int i = 0; i < 8; i++) begin
            xa = 8'($urandom); xb = 8'($urandom);
            A_bus = xa; B_bus = xb;
            @(posedge clk); #1;
            chk($sformatf("xor%0d_valid", i), out_valid, 1);
            chk($sformatf("xor%0d_res", i), {C, CF, ZF, NF, OF}, model(4'h8, xa, xb));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("xor_drain_idle", out_valid, 0);
        out_ready = 1'b0;

        run("pre_mul_pass", 4'h0, 8'hA5, 8'h00, model(4'h0, 8'hA5, 8'h00), 0);
        in_valid = 1'b1; F = 4'hE; A_bus = 8'h33; B_bus = 8'h44;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_result", {C, CF, ZF, NF, OF}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_release_in_ready", in_ready, 1);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("rst_no_stale", seen, 0);
        run("post_rst_add", 4'h2, 8'h02, 8'h03, {8'h05, 1'b0, 1'b0, 1'b0, 1'b0}, 0);

        for (int i = 0; i < 150; i++) begin
            logic [3:0] rf;
            logic [7:0] ra, rb;
            rf = 4'($urandom_range(0, 15));
            ra = 8'($urandom); rb = 8'($urandom);
            run($sformatf("rnd%0d_f%0h", i, rf), rf, ra, rb, model(rf, ra, rb), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
